// File: rtl/ece385_serial_cmp_pkg.sv
// Shared types for the serial nibble comparator: cascade result, FSM states
// and the cascade-input decode applied when operands are accepted.
package ece385_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_GT,
        CMP_LT
    } cmp_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Contradictory or absent gt/lt cascade inputs resolve to EQ.
    function automatic cmp_t cmp_init(input logic gt, input logic eq, input logic lt);
        cmp_t r;
        r = CMP_EQ;
        if (eq)
            r = CMP_EQ;
        else if (gt && !lt)
            r = CMP_GT;
        else if (lt && !gt)
            r = CMP_LT;
        return r;
    endfunction

endpackage

// File: rtl/ece385_serial_cmp_slice.sv
// One 7485-style nibble stage: a differing nibble decides, an equal one
// passes the cascade through.
module ece385_cmp_slice
    import ece385_cmp_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  cmp_t       cmp_i,
    output cmp_t       cmp_o
);

    always_comb begin
        cmp_o = cmp_i;
        if (a_i > b_i)
            cmp_o = CMP_GT;
        else if (a_i < b_i)
            cmp_o = CMP_LT;
    end

endmodule

// File: rtl/ece385_serial_cmp.sv
// Multi-nibble magnitude comparator that walks the operands LSB nibble first
// through a single slice, with valid/ready handshakes on both sides.
module ece385_serial_cmp
    import ece385_cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             A_gt_B_in,
    input  logic             A_eq_B_in,
    input  logic             A_lt_B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             A_gt_B_out,
    output logic             A_eq_B_out,
    output logic             A_lt_B_out
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
        $error("ece385_serial_cmp: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state_q, state_d;
    cmp_t             acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             ov_q, ov_d;
    logic [2:0]       res_q, res_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    cmp_t             slice_cmp;

    assign a_sh = a_q >> {cnt_q, 2'b00};
    assign b_sh = b_q >> {cnt_q, 2'b00};

    ece385_cmp_slice u_slice (
        .a_i   (a_sh[3:0]),
        .b_i   (b_sh[3:0]),
        .cmp_i (acc_q),
        .cmp_o (slice_cmp)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ov_d    = ov_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    acc_d   = cmp_init(A_gt_B_in, A_eq_B_in, A_lt_B_in);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = slice_cmp;
                cnt_d = cnt_q + 1'b1;
                // Outputs are loaded here so they come straight from flops in DONE.
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    ov_d    = 1'b1;
                    res_d   = {slice_cmp == CMP_GT, slice_cmp == CMP_EQ, slice_cmp == CMP_LT};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    ov_d    = 1'b0;
                    res_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ov_d    = 1'b0;
                res_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            acc_q   <= CMP_EQ;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ov_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !Reset;
    assign out_valid  = ov_q;
    assign A_gt_B_out = res_q[2];
    assign A_eq_B_out = res_q[1];
    assign A_lt_B_out = res_q[0];

endmodule
